// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register map, field indices and shifter state type for mmio_uart_tx
package uart_mmio_pkg;
  localparam logic [1:0] TXDATA_OFF = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;
  localparam logic [1:0] DIVISOR_OFF = 2'd2;
  localparam logic [1:0] CTRL_OFF = 2'd3;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT_LO = 4;
  localparam int CTRL_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rp_q];
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = din;
    wp_d = do_push ? wp_q + AW'(1) : wp_q;
    rp_d = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and level irq
module mmio_uart_tx import uart_mmio_pkg::*; #(
  parameter int CLK_DIV_DEFAULT = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, fifo_dout;
  logic tx_q, tx_d, irq_q, irq_d, en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
  logic wr, rd, push, pop, full, empty, busy, tick, go;
  logic [CW-1:0] fifo_cnt;
  logic [3:0] cnt_sat;
  logic [31:0] status;
  logic [1:0] off;
  logic unused_bits;
  assign unused_bits = ^{address[31:4], address[1:0], writeData[31:16]};
  assign tx = tx_q;
  assign irq = irq_q;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(writeData[7:0]),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(fifo_cnt)
  );
  always_comb begin
    off = address[3:2];
    wr = sel & memWrite;
    rd = sel & memRead;
    push = wr & (off == TXDATA_OFF);
    div_d = (wr & (off == DIVISOR_OFF)) ? writeData[15:0] : div_q;
    en_d = (wr & (off == CTRL_OFF)) ? writeData[CTRL_EN] : en_q;
    irq_en_d = (wr & (off == CTRL_OFF)) ? writeData[CTRL_IRQ_EN] : irq_en_q;
    ovf_d = (push & full & ~pop) | (ovf_q & ~(wr & (off == STATUS_OFF) & writeData[ST_OVF]));
    irq_d = irq_en_q & empty & ~busy;
    cnt_sat = (32'(fifo_cnt) > 32'd15) ? 4'hf : 4'(fifo_cnt);
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = busy;
    status[ST_OVF] = ovf_q;
    status[ST_CNT_LO +: 4] = cnt_sat;
    readData = ~rd ? '0 :
               (off == STATUS_OFF) ? status :
               (off == DIVISOR_OFF) ? {16'h0, div_q} :
               (off == CTRL_OFF) ? {30'h0, irq_en_q, en_q} : '0;
  end
  always_comb begin
    div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    tick = cnt_q == 16'd1;
    go = en_q & ~empty;
    state_d = state_q;
    cnt_d = (state_q == IDLE) ? cnt_q : cnt_q - 16'd1;
    bit_d = bit_q;
    sh_d = sh_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d = START;
        pop = 1'b1;
        sh_d = fifo_dout;
        cnt_d = div_eff;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = 3'd0;
        cnt_d = div_eff;
      end
      DATA: if (tick) begin
        state_d = (bit_q == 3'd7) ? STOP : DATA;
        bit_d = bit_q + 3'd1;
        sh_d = sh_q >> 1;
        cnt_d = div_eff;
      end
      STOP: if (tick) begin
        state_d = go ? START : IDLE;
        pop = go;
        sh_d = go ? fifo_dout : sh_q;
        cnt_d = div_eff;
      end
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
      irq_q <= 1'b0;
      div_q <= 16'(CLK_DIV_DEFAULT);
      en_q <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      irq_q <= irq_d;
      div_q <= div_d;
      en_q <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed scoreboard bench for mmio_uart_tx
module tb_mmio_uart_tx;
  import uart_mmio_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic memRead = 1'b0;
  logic memWrite = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic tx, irq;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  mmio_uart_tx dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .memRead(memRead),
    .memWrite(memWrite),
    .address(address),
    .writeData(writeData),
    .readData(readData),
    .tx(tx),
    .irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask
  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    sel = 1'b1;
    memWrite = 1'b1;
    address = {28'h0, off, 2'b00};
    writeData = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    memWrite = 1'b0;
  endtask
  task automatic rd(input logic [1:0] off, output logic [31:0] d);
    sel = 1'b1;
    memRead = 1'b1;
    address = {28'h0, off, 2'b00};
    #1;
    d = readData;
    sel = 1'b0;
    memRead = 1'b0;
  endtask
  task automatic chk_rd(input string tag, input logic [1:0] off, input logic [31:0] e);
    logic [31:0] d;
    rd(off, d);
    chk(tag, d, e);
  endtask
  task automatic push_byte(input logic [7:0] b, input bit accepted);
    wr(TXDATA_OFF, {24'h0, b});
    if (accepted) exp_q.push_back(b);
  endtask
  task automatic recv_frame(input string tag, input int div, input int maxwait);
    logic [9:0] obs;
    logic stable;
    logic [7:0] e;
    int w;
    w = 0;
    do begin
      tick();
      w++;
    end while (tx !== 1'b0 && w < maxwait);
    chk({tag, "_start"}, {31'h0, tx}, 32'h0);
    if (tx !== 1'b0) return;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    obs = '0;
    stable = 1'b1;
    for (int s = 0; s < 10 * div; s++) begin
      if (s > 0) tick();
      if (s % div == 0) obs[s / div] = tx;
      else if (tx !== obs[s / div]) stable = 1'b0;
    end
    chk(tag, {21'h0, stable, obs}, {21'h0, 1'b1, 1'b1, e, 1'b0});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk_rd("rst_status", STATUS_OFF, 32'h02);
    chk_rd("rst_div", DIVISOR_OFF, 32'd434);
    chk_rd("rst_ctrl", CTRL_OFF, 32'h1);
    wr(DIVISOR_OFF, 32'd4);
    push_byte(8'h55, 1'b1);
    chk("idle_after_store", {31'h0, tx}, 32'h1);
    chk_rd("status_after_push", STATUS_OFF, 32'h10);
    recv_frame("frame_55", 4, 1);
    tick();
    chk_rd("status_done", STATUS_OFF, 32'h02);
    wr(DIVISOR_OFF, 32'd0);
    chk_rd("div_zero_rd", DIVISOR_OFF, 32'h0);
    push_byte(8'ha5, 1'b1);
    recv_frame("frame_div0", 1, 1);
    wr(DIVISOR_OFF, 32'd2);
    wr(CTRL_OFF, 32'h0);
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i * 17), i < 8);
    chk_rd("status_ovf", STATUS_OFF, 32'h89);
    wr(STATUS_OFF, 32'h8);
    chk_rd("status_ovf_clr", STATUS_OFF, 32'h81);
    wr(CTRL_OFF, 32'h1);
    for (int i = 0; i < 8; i++) recv_frame("burst", 2, 1);
    tick();
    chk_rd("status_burst_done", STATUS_OFF, 32'h02);
    chk("sb_empty", exp_q.size(), 32'h0);
    push_byte(8'hc3, 1'b1);
    fork
      recv_frame("frame_pre_dis", 2, 1);
      begin
        push_byte(8'h3a, 1'b1);
        wr(CTRL_OFF, 32'h0);
      end
    join
    repeat (4) tick();
    chk("dis_tx_high", {31'h0, tx}, 32'h1);
    chk_rd("dis_status", STATUS_OFF, 32'h10);
    wr(CTRL_OFF, 32'h1);
    recv_frame("frame_resume", 2, 1);
    wr(CTRL_OFF, 32'h0);
    push_byte(8'h3c, 1'b1);
    wr(CTRL_OFF, 32'h3);
    fork
      recv_frame("frame_irq", 2, 1);
      begin
        repeat (5) tick();
        chk("irq_mid_frame", {31'h0, irq}, 32'h0);
      end
    join
    tick();
    chk("irq_stop_end", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_rise", {31'h0, irq}, 32'h1);
    push_byte(8'h81, 1'b1);
    fork
      recv_frame("frame_irq2", 2, 1);
      begin
        chk("irq_at_push", {31'h0, irq}, 32'h1);
        tick();
        chk("irq_drop", {31'h0, irq}, 32'h0);
      end
    join
    wr(DIVISOR_OFF, 32'd4);
    push_byte(8'h00, 1'b1);
    push_byte(8'hab, 1'b1);
    repeat (5) tick();
    chk("data_tx_low", {31'h0, tx}, 32'h0);
    chk_rd("data_status", STATUS_OFF, 32'h14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("rst_mid_tx", {31'h0, tx}, 32'h1);
    chk_rd("rst_mid_status", STATUS_OFF, 32'h02);
    chk_rd("rst_mid_div", DIVISOR_OFF, 32'd434);
    chk_rd("rst_mid_ctrl", CTRL_OFF, 32'h1);
    chk_rd("txdata_reads0", TXDATA_OFF, 32'h0);
    sel = 1'b0;
    memRead = 1'b1;
    address = {28'h0, STATUS_OFF, 2'b00};
    #1;
    chk("nosel_read", readData, 32'h0);
    memRead = 1'b0;
    sel = 1'b1;
    #1;
    chk("noread_sel", readData, 32'h0);
    sel = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the RV32I core's data-memory load/store accesses. A top-level address decoder asserts `sel` when an access falls in the peripheral's 16-byte window. Stored bytes are queued in a FIFO and shifted out as 8N1 serial frames on `tx`. Loads return register contents in the same cycle, as the single-cycle core requires.

## Interface
- `CLK_DIV_DEFAULT`, default 434: reset value of DIVISOR, the clocks per bit (50 MHz / 115200).
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2, at least 2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `sel`  in  1  access targets this peripheral.
- `memRead`  in  1  load strobe.
- `memWrite`  in  1  store strobe.
- `address`  in  32  byte address; only `[3:2]` is decoded.
- `writeData`  in  32  store data.
- `readData`  out  32  load data; combinational.
- `tx`  out  1  serial line; idles high.
- `irq`  out  1  level interrupt.

## Operation
- Register map (offset from `address[3:2]`):
  - 0x0 TXDATA. Write pushes `writeData[7:0]`. Reads 0.
  - 0x4 STATUS. Read-only fields: bit0 full, bit1 empty, bit2 busy, bits[7:4] FIFO count (saturates at 15).
  - 0x4 STATUS bit3 overflow: sticky; write 1 to clear.
  - 0x8 DIVISOR. RW, bits[15:0]. A value of 0 is treated as 1.
  - 0xC CTRL. RW. bit0 enable (reset 1), bit1 irq_en (reset 0).
- Writes take effect only when `sel & memWrite`.
- `readData` equals the selected register when `sel & memRead`, and 0 otherwise. Unused bits read 0.
- Push to TXDATA while full, with no pop in the same cycle: the byte is dropped and overflow is set. Push and pop in the same cycle while full: the push is accepted.
- FSM states:
  - IDLE: `tx`=1. If enable and FIFO non-empty, pop and go to START.
  - START: `tx`=0.
  - DATA: 8 bits, LSB first.
  - STOP: `tx`=1. On the last STOP cycle, if enable and FIFO non-empty, pop and go to START (no idle gap). Otherwise go to IDLE.
- Each state or bit lasts DIVISOR cycles, counted by a 16-bit down-counter.
- busy = FSM not in IDLE.
- Clearing enable mid-frame: the current frame completes, then the FSM holds in IDLE.
- A DIVISOR write mid-frame takes effect at the next bit boundary. The current bit keeps its length.
- `irq` = irq_en & empty & ~busy. It is registered: it updates one cycle after its inputs change.

## Timing
- Reset values: `tx`=1, `irq`=0, FSM=IDLE, FIFO empty, overflow=0, DIVISOR=`CLK_DIV_DEFAULT`, CTRL=0x1.
- `readData` has zero-cycle latency. A read in the same cycle as a push returns pre-push state.
- Push in cycle N into an empty FIFO with the FSM idle:
  - cycle N+1: pop, enter START;
  - `tx` falls at N+1;
  - frame occupies 10×DIVISOR cycles.
- Back-to-back frames are contiguous.
- STATUS reflects a push from cycle N+1.
- `rst` mid-frame: `tx` returns to 1 the next cycle and FIFO contents are discarded.

## Structure
- Package `uart_mmio_pkg` holds:
  - register offset localparams (`TXDATA_OFF`, `STATUS_OFF`, `DIVISOR_OFF`, `CTRL_OFF`);
  - STATUS/CTRL bit indices;
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
- Sub-module `sync_fifo` (parameters WIDTH=8, DEPTH) with push, pop, full, empty, count.
- The shifter FSM and register decode live in `mmio_uart_tx`.

## Test plan
- Reset, then read STATUS → 0x02 (empty); read DIVISOR → 434; `tx`=1.
- DIVISOR=4, store 0x55 to TXDATA → `tx` shows 0,1,0,1,0,1,0,1,0,1, each 4 cycles, starting 1 cycle after the store; then busy=0.
- DIVISOR=2, store 9 bytes without draining → 9th store sets overflow, count=8. Write 0x8 to STATUS → overflow=0. Eight frames are sent contiguously.
- Store two bytes, clear enable during frame 1 → frame 1 completes, `tx` stays high, count=1. Set enable → frame 2 starts the next cycle.
- irq_en=1 with one byte queued → `irq`=0 during the frame, rises 1 cycle after STOP ends. Push a byte → `irq` drops the cycle after the push.
- Assert `rst` during the DATA state → `tx`=1 and STATUS=0x02 the next cycle. A load with `sel`=0 → `readData`=0.
